// File: rtl/sm83_fetch.sv
// SM83 instruction fetch stage.
// Pulls opcode bytes from the memory bus at PC and follows the 0xCB prefix.
// Collects 0..2 immediate bytes and presents one instruction record to
// decode/execute over a valid/ready handshake. Execute redirects PC with pc_load.
// Optional feature macro: SM83_HALT_BUG_EN (HALT-bug PC freeze on the next opcode).
module sm83_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        halt_bug,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_op,
  output logic        instr_cb,
  output logic [15:0] instr_imm,
  output logic [1:0]  instr_imm_len,
  output logic        instr_illegal,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_next
);

  typedef enum logic [2:0] {StOp, StCb, StImmLo, StImmHi, StHold} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  op_q, op_d;
  logic        cb_q, cb_d;
  logic [15:0] imm_q, imm_d;
  logic [1:0]  len_q, len_d;
  logic        illegal_q, illegal_d;
  logic [15:0] ipc_q, ipc_d;
  logic        halt_skip;

  // Immediate byte count for an unprefixed opcode.
  function automatic logic [1:0] imm_len_of(input logic [7:0] op);
    unique case (op)
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'hE0, 8'hF0, 8'hE8, 8'hF8:                               imm_len_of = 2'd1;
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08,
      8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA:          imm_len_of = 2'd2;
      default:                                                  imm_len_of = 2'd0;
    endcase
  endfunction

  // Unused holes in the unprefixed opcode map.
  function automatic logic is_illegal(input logic [7:0] op);
    unique case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD:        is_illegal = 1'b1;
      default:                                  is_illegal = 1'b0;
    endcase
  endfunction

`ifdef SM83_HALT_BUG_EN
  logic halt_q, halt_d;

  // One-shot HALT-bug flag: armed by the pulse, spent on the next opcode byte.
  always_comb begin
    halt_d = halt_q;
    if (pc_load) begin
      halt_d = 1'b0;
    end else if (halt_bug) begin
      halt_d = 1'b1;
    end else if (state_q == StOp && mem_ack) begin
      halt_d = 1'b0;
    end
  end

  // HALT-bug flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end

  assign halt_skip = halt_q;
`else
  logic unused_halt_bug;
  assign unused_halt_bug = halt_bug;
  assign halt_skip       = 1'b0;
`endif

  // Next-state, PC advance and record assembly; redirect overrides everything.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    cb_d      = cb_q;
    imm_d     = imm_q;
    len_d     = len_q;
    illegal_d = illegal_q;
    ipc_d     = ipc_q;
    if (pc_load) begin
      // A same-cycle ack is dropped; the partial record is abandoned.
      pc_d    = pc_load_val;
      state_d = StOp;
    end else begin
      unique case (state_q)
        StOp: begin
          if (mem_ack) begin
            ipc_d = pc_q;
            pc_d  = halt_skip ? pc_q : pc_q + 16'd1;
            if (mem_rdata == 8'hCB) begin
              state_d = StCb;
            end else begin
              op_d      = mem_rdata;
              cb_d      = 1'b0;
              imm_d     = 16'h0000;
              len_d     = imm_len_of(mem_rdata);
              illegal_d = is_illegal(mem_rdata);
              state_d   = (imm_len_of(mem_rdata) == 2'd0) ? StHold : StImmLo;
            end
          end
        end
        StCb: begin
          if (mem_ack) begin
            pc_d      = pc_q + 16'd1;
            op_d      = mem_rdata;
            cb_d      = 1'b1;
            imm_d     = 16'h0000;
            len_d     = 2'd0;
            illegal_d = 1'b0;
            state_d   = StHold;
          end
        end
        StImmLo: begin
          if (mem_ack) begin
            pc_d       = pc_q + 16'd1;
            imm_d[7:0] = mem_rdata;
            state_d    = (len_q == 2'd2) ? StImmHi : StHold;
          end
        end
        StImmHi: begin
          if (mem_ack) begin
            pc_d        = pc_q + 16'd1;
            imm_d[15:8] = mem_rdata;
            state_d     = StHold;
          end
        end
        StHold: begin
          if (instr_ready) begin
            state_d = StOp;
          end
        end
        default: state_d = StOp;
      endcase
    end
  end

  // State, PC and record registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StOp;
      pc_q      <= RESET_PC;
      op_q      <= 8'h00;
      cb_q      <= 1'b0;
      imm_q     <= 16'h0000;
      len_q     <= 2'd0;
      illegal_q <= 1'b0;
      ipc_q     <= 16'h0000;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      cb_q      <= cb_d;
      imm_q     <= imm_d;
      len_q     <= len_d;
      illegal_q <= illegal_d;
      ipc_q     <= ipc_d;
    end
  end

  // Bus request and record presentation.
  always_comb begin
    mem_req       = (state_q != StHold);
    mem_addr      = pc_q;
    instr_valid   = (state_q == StHold);
    instr_op      = op_q;
    instr_cb      = cb_q;
    instr_imm     = imm_q;
    instr_imm_len = len_q;
    instr_illegal = illegal_q;
    instr_pc      = ipc_q;
    pc_next       = pc_q;
  end

endmodule

// File: tb/tb_sm83_fetch.sv
// Directed bench for sm83_fetch with a flat 64 KiB byte memory that acks
// combinationally whenever ack_en is set.
module tb_sm83_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        halt_bug;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_op;
  logic        instr_cb;
  logic [15:0] instr_imm;
  logic [1:0]  instr_imm_len;
  logic        instr_illegal;
  logic [15:0] instr_pc;
  logic [15:0] pc_next;

  logic [7:0]  mem [0:65535];
  logic        ack_en;
  int          rd_cnt;
  int          tests;
  int          fails;

  sm83_fetch #(.RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .pc_load       (pc_load),
    .pc_load_val   (pc_load_val),
    .halt_bug      (halt_bug),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_op      (instr_op),
    .instr_cb      (instr_cb),
    .instr_imm     (instr_imm),
    .instr_imm_len (instr_imm_len),
    .instr_illegal (instr_illegal),
    .instr_pc      (instr_pc),
    .pc_next       (pc_next)
  );

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = ack_en & mem_req;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count bytes actually consumed by the fetch unit (redirect cycles drop the ack).
  always @(posedge clk) begin
    if (rst_n && mem_req && mem_ack && !pc_load) rd_cnt <= rd_cnt + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] addr);
    pc_load     = 1'b1;
    pc_load_val = addr;
    step();
    pc_load     = 1'b0;
  endtask

  task automatic accept;
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
  endtask

  // Cycles until instr_valid, bounded at 20.
  task automatic wait_valid(output int n);
    n = 0;
    while (!instr_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'h0000 || instr_op !== 8'h00 ||
        instr_imm !== 16'h0000 || instr_imm_len !== 2'd0 || instr_pc !== 16'h0000 ||
        pc_next !== 16'h0000 || instr_cb !== 1'b0 || instr_illegal !== 1'b0) begin
      fails++;
      $display("FAIL reset: valid=%b addr=%h op=%h imm=%h len=%0d pc=%h next=%h, want all 0",
               instr_valid, mem_addr, instr_op, instr_imm, instr_imm_len, instr_pc, pc_next);
    end
  endtask

  task automatic test_first_nop;
    ack_en = 1'b1;
    step();
    rst_n = 1'b1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL t1_req: req=%b addr=%h, want 1 0000", mem_req, mem_addr);
    end
    step();
    tests++;
    if (instr_valid !== 1'b1 || instr_op !== 8'h00 || instr_imm_len !== 2'd0 ||
        instr_pc !== 16'h0000 || pc_next !== 16'h0001) begin
      fails++;
      $display("FAIL t1_rec: valid=%b op=%h len=%0d pc=%h next=%h, want 1 00 0 0000 0001",
               instr_valid, instr_op, instr_imm_len, instr_pc, pc_next);
    end
    accept();
  endtask

  task automatic test_imm16;
    int n;
    int r0;
    mem[16'h0100] = 8'h01; mem[16'h0101] = 8'h34; mem[16'h0102] = 8'h12;
    do_load(16'h0100);
    r0 = rd_cnt;
    wait_valid(n);
    tests++;
    if (n != 3 || rd_cnt - r0 != 3) begin
      fails++;
      $display("FAIL t2_lat: cycles=%0d reads=%0d, want 3 3", n, rd_cnt - r0);
    end
    tests++;
    if (instr_op !== 8'h01 || instr_imm !== 16'h1234 || instr_imm_len !== 2'd2 ||
        instr_pc !== 16'h0100 || pc_next !== 16'h0103 || instr_cb !== 1'b0) begin
      fails++;
      $display("FAIL t2_rec: op=%h imm=%h len=%0d pc=%h next=%h cb=%b, want 01 1234 2 0100 0103 0",
               instr_op, instr_imm, instr_imm_len, instr_pc, pc_next, instr_cb);
    end
    accept();
  endtask

  task automatic test_cb_and_imm8;
    int n;
    mem[16'h0200] = 8'hCB; mem[16'h0201] = 8'h37;
    mem[16'h0202] = 8'hE0; mem[16'h0203] = 8'h55;
    mem[16'h0204] = 8'h00;
    do_load(16'h0200);
    wait_valid(n);
    tests++;
    if (n != 2 || instr_op !== 8'h37 || instr_cb !== 1'b1 || instr_imm_len !== 2'd0 ||
        instr_imm !== 16'h0000 || instr_pc !== 16'h0200 || pc_next !== 16'h0202) begin
      fails++;
      $display("FAIL t3_cb: n=%0d op=%h cb=%b len=%0d imm=%h pc=%h next=%h, want 2 37 1 0 0000 0200 0202",
               n, instr_op, instr_cb, instr_imm_len, instr_imm, instr_pc, pc_next);
    end
    accept();
    tests++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0202) begin
      fails++;
      $display("FAIL t3_idle: valid=%b req=%b addr=%h, want 0 1 0202",
               instr_valid, mem_req, mem_addr);
    end
    wait_valid(n);
    tests++;
    if (n != 2 || instr_op !== 8'hE0 || instr_cb !== 1'b0 || instr_imm !== 16'h0055 ||
        instr_imm_len !== 2'd1 || instr_pc !== 16'h0202 || pc_next !== 16'h0204) begin
      fails++;
      $display("FAIL t3_imm8: n=%0d op=%h cb=%b imm=%h len=%0d pc=%h next=%h, want 2 E0 0 0055 1 0202 0204",
               n, instr_op, instr_cb, instr_imm, instr_imm_len, instr_pc, pc_next);
    end
  endtask

  // Continues from the E0 55 record left in hold by test_cb_and_imm8.
  task automatic test_hold;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if (instr_valid !== 1'b1 || mem_req !== 1'b0 || instr_op !== 8'hE0 ||
          instr_imm !== 16'h0055 || instr_pc !== 16'h0202 || pc_next !== 16'h0204) begin
        fails++;
        $display("FAIL t4_hold%0d: valid=%b req=%b op=%h imm=%h pc=%h next=%h, want 1 0 E0 0055 0202 0204",
                 i, instr_valid, mem_req, instr_op, instr_imm, instr_pc, pc_next);
      end
    end
    accept();
    tests++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0204) begin
      fails++;
      $display("FAIL t4_release: valid=%b req=%b addr=%h, want 0 1 0204",
               instr_valid, mem_req, mem_addr);
    end
  endtask

  task automatic test_redirect_mid;
    int n;
    mem[16'h0400] = 8'h3E; mem[16'h0401] = 8'h99;
    mem[16'h0038] = 8'h00;
    do_load(16'h0400);
    step();
    do_load(16'h0038);
    tests++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'h0038 || pc_next !== 16'h0038) begin
      fails++;
      $display("FAIL t5_redir: valid=%b addr=%h next=%h, want 0 0038 0038",
               instr_valid, mem_addr, pc_next);
    end
    wait_valid(n);
    tests++;
    if (n != 1 || instr_op !== 8'h00 || instr_pc !== 16'h0038 || pc_next !== 16'h0039) begin
      fails++;
      $display("FAIL t5_after: n=%0d op=%h pc=%h next=%h, want 1 00 0038 0039",
               n, instr_op, instr_pc, pc_next);
    end
    accept();
  endtask

  task automatic test_stall_illegal;
    int n;
    mem[16'h0600] = 8'hC3; mem[16'h0601] = 8'hAB; mem[16'h0602] = 8'hCD;
    mem[16'h0603] = 8'hD3;
    do_load(16'h0600);
    step();
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    tests++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0601) begin
      fails++;
      $display("FAIL stall: valid=%b req=%b addr=%h, want 0 1 0601", instr_valid, mem_req, mem_addr);
    end
    ack_en = 1'b1;
    wait_valid(n);
    tests++;
    if (n != 2 || instr_op !== 8'hC3 || instr_imm !== 16'hCDAB || pc_next !== 16'h0603) begin
      fails++;
      $display("FAIL stall_rec: n=%0d op=%h imm=%h next=%h, want 2 C3 CDAB 0603",
               n, instr_op, instr_imm, pc_next);
    end
    accept();
    wait_valid(n);
    tests++;
    if (n != 1 || instr_op !== 8'hD3 || instr_illegal !== 1'b1 || instr_imm_len !== 2'd0 ||
        instr_imm !== 16'h0000 || pc_next !== 16'h0604) begin
      fails++;
      $display("FAIL illegal: n=%0d op=%h ill=%b len=%0d imm=%h next=%h, want 1 D3 1 0 0000 0604",
               n, instr_op, instr_illegal, instr_imm_len, instr_imm, pc_next);
    end
    accept();
  endtask

  task automatic test_halt_bug;
    int n;
    mem[16'h0300] = 8'h3C; mem[16'h0301] = 8'h00;
    ack_en = 1'b0;
    do_load(16'h0300);
    halt_bug = 1'b1;
    step();
    halt_bug = 1'b0;
    ack_en = 1'b1;
    wait_valid(n);
`ifdef SM83_HALT_BUG_EN
    tests++;
    if (n != 1 || instr_op !== 8'h3C || instr_pc !== 16'h0300 || pc_next !== 16'h0300) begin
      fails++;
      $display("FAIL t6_first: n=%0d op=%h pc=%h next=%h, want 1 3C 0300 0300",
               n, instr_op, instr_pc, pc_next);
    end
    accept();
    wait_valid(n);
    tests++;
    if (n != 1 || instr_op !== 8'h3C || instr_pc !== 16'h0300 || pc_next !== 16'h0301) begin
      fails++;
      $display("FAIL t6_second: n=%0d op=%h pc=%h next=%h, want 1 3C 0300 0301",
               n, instr_op, instr_pc, pc_next);
    end
`else
    tests++;
    if (n != 1 || instr_op !== 8'h3C || instr_pc !== 16'h0300 || pc_next !== 16'h0301) begin
      fails++;
      $display("FAIL t6_ignored: n=%0d op=%h pc=%h next=%h, want 1 3C 0300 0301",
               n, instr_op, instr_pc, pc_next);
    end
`endif
    accept();
    wait_valid(n);
    tests++;
    if (n != 1 || instr_op !== 8'h00 || instr_pc !== 16'h0301 || pc_next !== 16'h0302) begin
      fails++;
      $display("FAIL t6_next: n=%0d op=%h pc=%h next=%h, want 1 00 0301 0302",
               n, instr_op, instr_pc, pc_next);
    end
    accept();
  endtask

  task automatic test_wrap;
    int n;
    mem[16'hFFFF] = 8'h00;
    ack_en = 1'b0;
    do_load(16'hFFFF);
    ack_en = 1'b1;
    wait_valid(n);
    tests++;
    if (n != 1 || instr_pc !== 16'hFFFF || pc_next !== 16'h0000) begin
      fails++;
      $display("FAIL t7_wrap: n=%0d pc=%h next=%h, want 1 FFFF 0000", n, instr_pc, pc_next);
    end
    accept();
    tests++;
    if (mem_addr !== 16'h0000) begin
      fails++;
      $display("FAIL t7_addr: addr=%h, want 0000", mem_addr);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    mem[16'h0700] = 8'h01;
    do_load(16'h0700);
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'h0000 || instr_imm_len !== 2'd0) begin
      fails++;
      $display("FAIL rst_mid: valid=%b addr=%h len=%0d, want 0 0000 0",
               instr_valid, mem_addr, instr_imm_len);
    end
    step();
    rst_n = 1'b1;
    wait_valid(n);
    tests++;
    if (n != 1 || instr_op !== 8'h00 || instr_pc !== 16'h0000 || pc_next !== 16'h0001) begin
      fails++;
      $display("FAIL rst_restart: n=%0d op=%h pc=%h next=%h, want 1 00 0000 0001",
               n, instr_op, instr_pc, pc_next);
    end
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rd_cnt      = 0;
    ack_en      = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = 16'h0000;
    halt_bug    = 1'b0;
    instr_ready = 1'b0;
    rst_n       = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_first_nop();
    test_imm16();
    test_cb_and_imm8();
    test_hold();
    test_redirect_mid();
    test_stall_illegal();
    test_halt_bug();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
